// File: rtl/div_pkg.sv
// Shared constants and types for the RV32M divide sequencer.
// Imported by the interface, step datapath and sequencer top.
package div_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Execute-stage handshake between the control path and the divider.
// The pipeline side is master; the sequencer is slave.
interface div_sequencer_if #(
    parameter int XLEN = div_pkg::XLEN
);

    logic            Start;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] Operand_A;
    logic [XLEN-1:0] Operand_B;
    logic            Flush;
    logic            Stall;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;

    modport master (
        output Start,
        output Funct3,
        output Operand_A,
        output Operand_B,
        output Flush,
        input  Stall,
        input  Busy,
        input  Done,
        input  Result
    );

    modport slave (
        input  Start,
        input  Funct3,
        input  Operand_A,
        input  Operand_B,
        input  Flush,
        output Stall,
        output Busy,
        output Done,
        output Result
    );

endinterface

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift {rem, quo}, trial-subtract.
// Isolated so a higher-radix step can drop in without touching the FSM.
module div_step #(
    parameter int XLEN = div_pkg::XLEN
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quo_next
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem may exceed 2^(XLEN-1) for unsigned divisors, so keep the carry-out
    assign shifted = {rem, quo[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        rem_next = shifted[XLEN-1:0];
        quo_next = {quo[XLEN-2:0], 1'b0};
        if (!diff[XLEN]) begin
            rem_next = diff[XLEN-1:0];
            quo_next = {quo[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer for the execute stage.
// Stalls the front end while iterating, then strobes Done for one cycle.
module div_sequencer #(
    parameter int XLEN = div_pkg::XLEN
) (
    input logic           CLK,
    input logic           RST,
    div_sequencer_if.slave bus
);

    import div_pkg::*;

    localparam int CW = $clog2(XLEN);

    localparam logic [XLEN-1:0] MIN_NEG =
        {1'b1, {(XLEN-1){1'b0}}};

    state_t state;
    state_t state_n;

    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] dvsr_q;
    logic [XLEN-1:0] rem_n;
    logic [XLEN-1:0] quo_n;
    logic [CW-1:0]   cnt_q;
    logic            neg_quo_q;
    logic            neg_rem_q;
    logic            sel_rem_q;

    logic            accept;
    logic            is_signed;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;
    logic [XLEN-1:0] res_n;
    logic            load_res;

    logic            done_q;
    logic            busy_q;
    logic [XLEN-1:0] result_q;

    assign accept    = bus.Start & ~bus.Flush;
    assign is_signed = ~bus.Funct3[0];
    assign a_neg     = is_signed & bus.Operand_A[XLEN-1];
    assign b_neg     = is_signed & bus.Operand_B[XLEN-1];
    assign abs_a     = a_neg ? -bus.Operand_A : bus.Operand_A;
    assign abs_b     = b_neg ? -bus.Operand_B : bus.Operand_B;

    assign div_zero = bus.Operand_B == '0;
    assign ovf      = is_signed
                    & (bus.Operand_A == MIN_NEG)
                    & (bus.Operand_B == '1);

    // Early-out results are fixed by the ISA, taken from raw operands
    always_comb begin
        spec_res = '0;
        unique case (1'b1)
            div_zero:
                spec_res = bus.Funct3[1] ? bus.Operand_A : '1;
            default:
                spec_res = bus.Funct3[1] ? '0 : bus.Operand_A;
        endcase
    end

    assign quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix = neg_rem_q ? -rem_q : rem_q;

    div_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvsr_q),
        .rem_next (rem_n),
        .quo_next (quo_n)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        load_res = 1'b0;
        res_n    = '0;
        if (bus.Flush) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.Start) begin
                        if (div_zero | ovf) begin
                            state_n  = DONE;
                            load_res = 1'b1;
                            res_n    = spec_res;
                        end else begin
                            state_n = CALC;
                        end
                    end
                end
                CALC: begin
                    if (cnt_q == '0) begin
                        state_n = FIX;
                    end
                end
                FIX: begin
                    state_n  = DONE;
                    load_res = 1'b1;
                    res_n    = sel_rem_q ? rem_fix : quo_fix;
                end
                DONE: begin
                    state_n = IDLE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            sel_rem_q <= 1'b0;
        end else if (state == IDLE && accept) begin
            rem_q     <= '0;
            quo_q     <= abs_a;
            dvsr_q    <= abs_b;
            cnt_q     <= CW'(XLEN - 1);
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            sel_rem_q <= bus.Funct3[1];
        end else if (state == CALC) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Outputs registered from next-state so they track state exactly
    always_ff @(posedge CLK) begin
        if (RST) begin
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= state_n == DONE;
            busy_q <= state_n != IDLE;
            if (load_res) begin
                result_q <= res_n;
            end
        end
    end

    assign bus.Done   = done_q;
    assign bus.Busy   = busy_q;
    assign bus.Result = result_q;
    assign bus.Stall  = (state == IDLE & accept)
                      | (state == CALC)
                      | (state == FIX);

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and random checks of div_sequencer against an arithmetic model.
// Operations are driven and sampled on the falling edge.
module tb_div_sequencer;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    int tests = 0;
    int fails = 0;

    logic [31:0] last_res = '0;

    div_sequencer_if bus ();

    div_sequencer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] b
    );
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f3)
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b111: return (b == 0) ? a : a % b;
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && sb == -1) return a;
                return 32'(sa / sb);
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && sb == -1) return 0;
                return 32'(sa % sb);
            end
        endcase
    endfunction

    function automatic bit early(
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] b
    );
        if (b == 0) return 1'b1;
        return !f3[0] && a == 32'h8000_0000
            && b == 32'hFFFF_FFFF;
    endfunction

    // Start held high through the busy period, as a frozen pipeline would
    task automatic run_op(
        input string       tag,
        input logic [2:0]  f3,
        input logic [31:0] a,
        input logic [31:0] b
    );
        int  lat;
        int  stalls;
        int  extra;
        bit  got;
        int  exp_lat;
        logic [31:0] exp;
        exp     = model(f3, a, b);
        exp_lat = early(f3, a, b) ? 1 : 34;
        @(negedge CLK);
        bus.Start     = 1'b1;
        bus.Funct3    = f3;
        bus.Operand_A = a;
        bus.Operand_B = b;
        #1;
        lat    = 0;
        stalls = 0;
        got    = 1'b0;
        while (!got && lat < 100) begin
            if (bus.Stall) stalls++;
            if (bus.Done) begin
                got = 1'b1;
            end else begin
                @(negedge CLK);
                #1;
                lat++;
            end
        end
        bus.Start = 1'b0;
        chk({tag, " done_seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " stall_cycles"}, stalls, exp_lat);
        chk({tag, " result"}, bus.Result, exp);
        last_res = exp;
        extra = 0;
        repeat (3) begin
            @(negedge CLK);
            #1;
            if (bus.Done) extra++;
        end
        chk({tag, " extra_done"}, extra, 0);
        chk({tag, " busy_after"}, 32'(bus.Busy), 0);
    endtask

    initial begin
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        int          dn;

        bus.Start     = 1'b0;
        bus.Funct3    = 3'b101;
        bus.Operand_A = '0;
        bus.Operand_B = '0;
        bus.Flush     = 1'b0;

        repeat (3) @(negedge CLK);
        #1;
        chk("rst done", 32'(bus.Done), 0);
        chk("rst busy", 32'(bus.Busy), 0);
        chk("rst stall", 32'(bus.Stall), 0);
        chk("rst result", bus.Result, 0);
        RST = 1'b0;

        run_op("divu_100_7", 3'b101, 100, 7);
        run_op("remu_100_7", 3'b111, 100, 7);
        run_op("div_m7_2", 3'b100, -32'sd7, 2);
        run_op("rem_m7_2", 3'b110, -32'sd7, 2);
        run_op("rem_7_m2", 3'b110, 7, -32'sd2);
        run_op("div_5_0", 3'b100, 5, 0);
        run_op("remu_5_0", 3'b111, 5, 0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, '1);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, '1);
        run_op("divu_big", 3'b101, '1, 32'h8000_0001);

        // Abort with Flush at cycle k+10
        @(negedge CLK);
        bus.Start     = 1'b1;
        bus.Funct3    = 3'b101;
        bus.Operand_A = 50;
        bus.Operand_B = 7;
        repeat (10) @(negedge CLK);
        bus.Flush = 1'b1;
        bus.Start = 1'b0;
        @(negedge CLK);
        bus.Flush = 1'b0;
        #1;
        chk("flush busy", 32'(bus.Busy), 0);
        chk("flush done", 32'(bus.Done), 0);
        chk("flush stall", 32'(bus.Stall), 0);
        chk("flush result", bus.Result, last_res);
        dn = 0;
        repeat (40) begin
            @(negedge CLK);
            if (bus.Done) dn++;
        end
        chk("flush no_done", dn, 0);
        chk("flush result_hold", bus.Result, last_res);
        run_op("divu_9_3", 3'b101, 9, 3);

        // Reset at cycle k+5 aborts silently
        @(negedge CLK);
        bus.Start     = 1'b1;
        bus.Funct3    = 3'b100;
        bus.Operand_A = 1000;
        bus.Operand_B = 3;
        repeat (5) @(negedge CLK);
        RST       = 1'b1;
        bus.Start = 1'b0;
        @(negedge CLK);
        #1;
        chk("midrst done", 32'(bus.Done), 0);
        chk("midrst busy", 32'(bus.Busy), 0);
        chk("midrst stall", 32'(bus.Stall), 0);
        chk("midrst result", bus.Result, 0);
        RST = 1'b0;
        dn  = 0;
        repeat (40) begin
            @(negedge CLK);
            if (bus.Done) dn++;
        end
        chk("midrst no_done", dn, 0);

        for (int i = 0; i < 20; i++) begin
            rf3 = 3'b100 | 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = -32'($urandom_range(1, 15));
                3: begin
                    ra = 32'h8000_0000;
                    rb = '1;
                end
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), rf3, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
